vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- VGA sink: takes the 1-bit-per-colour RGB plus active-low hsync/vsync stream that the timing generator produces, clocked on the same pixel clock.
- Recovers pixel coordinates and checks line and frame timing against the parameters.
- Asserts lock after consecutive good frames.
- Re-emits active-area pixels with x/y tags. Used as an on-chip loopback checker and as the front end of a frame capture path.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_SYNC_START, 656, x of the first hsync-low sample
- H_SYNC_END, 752, x of the first hsync-high sample after the pulse
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, visible lines
- V_SYNC_START, 490, y of the first vsync-low line
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames needed to assert locked (1..15)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high; clears all state
- hsync_in  in  1  active-low horizontal sync
- vsync_in  in  1  active-low vertical sync
- rgb_in  in  3  bit0=red, bit1=green, bit2=blue
- pix_x  out  10  recovered x of the output pixel
- pix_y  out  10  recovered y of the output pixel
- pix_valid  out  1  output pixel is in the active area and locked=1
- red_out / green_out / blue_out  out  1 each  colour bits, forced 0 when pix_valid=0
- frame_start  out  1  one-cycle pulse with pix_valid at x=0, y=0
- locked  out  1  timing lock
- sync_err  out  1  one-cycle pulse on any timing violation

Behaviour:

Reset:
- All outputs 0; h_cnt, v_cnt, line/frame measurement counters and lock_cnt = 0.
- Stage-1 sync registers reset to 0, so a sync held low through reset release produces no edge.
- Measurement-valid flags are cleared.

Stage 1 (registered):
- s_hsync, s_vsync, s_rgb capture the inputs.
- h_cnt and v_cnt give the position of the stage-1 sample.

Horizontal:
- hfall = hsync_in==0 && s_hsync==1.
- On hfall: h_cnt <= H_SYNC_START.
- Otherwise: h_cnt <= (h_cnt==H_TOTAL-1) ? 0 : h_cnt+1.
- Hsync rising edge (hsync_in==1 && s_hsync==0): measured low width must equal H_SYNC_END-H_SYNC_START.

Line length:
- Counted between successive hfall.
- On hfall with h_meas_valid=1 and count != H_TOTAL → h violation.
- The first hfall after reset only sets h_meas_valid.

Vertical:
- v_cnt increments (wrapping at V_TOTAL-1) when h_cnt wraps H_TOTAL-1→0 without hfall.
- vfall = vsync_in==0 && s_vsync==1: v_cnt <= V_SYNC_START. This has priority over the increment in the same cycle.
- Lines between successive vfall, counted on h wraps, must equal V_TOTAL when v_meas_valid=1, otherwise v violation.
- The first vfall only sets v_meas_valid.

Violations:
- Any h, width or v violation → sync_err=1 for one cycle (stage 2), locked<=0, lock_cnt<=0.
- A frame-bad flag is also set; it is cleared at the next vfall.
- Simultaneous violations produce a single pulse.

Lock:
- At a vfall with v_meas_valid=1, frame length good and frame-bad clear: lock_cnt saturates-increments; locked<=1 when lock_cnt reaches LOCK_FRAMES.
- After a violation, lock is re-acquired only through fresh good frames.

Stage 2 (registered, total latency 2 clocks input→output):
- pix_x<=h_cnt, pix_y<=v_cnt.
- pix_valid <= locked && h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- Colours <= pix_valid ? s_rgb : 0.
- frame_start <= pix_valid && h_cnt==0 && v_cnt==0.
- pix_x/pix_y update even when unlocked.

Reset mid-frame:
- Immediate clear; lock needs LOCK_FRAMES+1 vfalls after release.
- No sync_err is generated by the first partial line or frame after reset.

Test Plan:
- Ideal 800x525 stream from the timing generator, rgb_in=3'b101 constant → locked rises at the 3rd vfall; afterwards pix_valid is high for exactly 640 clocks per active line and 480 lines per frame; red_out=1, green_out=0, blue_out=1 while valid; sync_err never pulses.
- Locked stream, rgb_in toggling each clock; check frame_start → exactly one pulse per 420000 clocks, coincident with pix_x=0, pix_y=0, pix_valid=1; output colour equals rgb_in from 2 clocks earlier.
- Locked stream, one line lengthened to 801 clocks → one sync_err pulse, locked falls the same cycle; re-locks after 2 subsequent clean frames at the following vfalls.
- Hsync low width 95 instead of 96 on one line → sync_err pulse at the hsync rising edge, locked=0.
- Frame of 524 lines → sync_err at the vfall ending it; no pix_valid until relock.
- Assert reset for 3 clocks mid-active-area with hsync low → all outputs 0 during reset, no sync_err after release, locked again after 3 vfalls.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// ----------------------------------------------------------------------------
// vga_sync_decoder
//
// VGA sink for a 1-bit-per-colour RGB stream with active-low hsync/vsync that
// shares the pixel clock with its source. Recovers pixel coordinates from the
// sync edges and checks line length, hsync pulse width and frame length
// against the parameters. It declares lock after LOCK_FRAMES consecutive good
// frames and re-emits the active-area pixels tagged with x/y.
//
// Pipeline:
//   stage 1  samples the inputs and tracks the position (h_cnt_r/v_cnt_r) of
//            the sample held in s_hsync_r/s_vsync_r/s_rgb_r.
//   stage 2  registers the tagged pixel. Input to output latency is 2 clocks.
//   sync_err and locked are registered at the edge that detects a violation,
//   so they fall and rise together.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-high; clears all state
//   hsync_in     active-low horizontal sync
//   vsync_in     active-low vertical sync
//   rgb_in[2:0]  bit0 = red, bit1 = green, bit2 = blue
//   pix_x        recovered x of the output pixel
//   pix_y        recovered y of the output pixel
//   pix_valid    output pixel lies in the active area and timing is locked
//   red_out / green_out / blue_out  colour bits, 0 when pix_valid is 0
//   frame_start  one-cycle pulse together with pix_valid at x=0, y=0
//   locked       timing lock
//   sync_err     one-cycle pulse on any timing violation
// ----------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_TOTAL      = 525,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] rgb_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_valid,
    output logic       red_out,
    output logic       green_out,
    output logic       blue_out,
    output logic       frame_start,
    output logic       locked,
    output logic       sync_err
);

    localparam logic [9:0]  H_LAST_C       = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST_C       = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACTIVE_C     = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACTIVE_C     = 10'(V_ACTIVE);
    localparam logic [9:0]  H_SYNC_START_C = 10'(H_SYNC_START);
    localparam logic [9:0]  V_SYNC_START_C = 10'(V_SYNC_START);
    localparam logic [10:0] H_TOTAL_C      = 11'(H_TOTAL);
    localparam logic [10:0] H_WIDTH_C      = 11'(H_SYNC_END - H_SYNC_START);
    localparam logic [10:0] V_TOTAL_C      = 11'(V_TOTAL);
    localparam logic [10:0] MEAS_MAX_C     = 11'h7FF;
    localparam logic [3:0]  LOCK_FRAMES_C  = 4'(LOCK_FRAMES);
    localparam logic [3:0]  LOCK_MAX_C     = 4'hF;

    // Stage-1 sample and position
    logic       s_hsync_r;
    logic       s_vsync_r;
    logic [2:0] s_rgb_r;
    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;

    // Measurement state
    logic [10:0] h_len_r;        // clocks since the last hfall
    logic [10:0] v_len_r;        // line wraps since the last vfall
    logic        h_meas_valid_r;
    logic        v_meas_valid_r;
    logic        frame_bad_r;
    logic [3:0]  lock_cnt_r;

    // Combinational helpers
    logic        hfall_s;
    logic        hrise_s;
    logic        vfall_s;
    logic        h_wrap_s;
    logic [9:0]  h_cnt_nx_s;
    logic [9:0]  v_cnt_nx_s;
    logic [10:0] h_len_nx_s;
    logic [10:0] v_lines_s;
    logic [10:0] v_len_nx_s;
    logic [3:0]  lock_inc_s;
    logic        h_viol_s;
    logic        w_viol_s;
    logic        v_viol_s;
    logic        any_viol_s;
    logic        frame_good_s;
    logic        pix_valid_nx_s;

    assign hfall_s  = ~hsync_in & s_hsync_r;
    assign hrise_s  = hsync_in & ~s_hsync_r;
    assign vfall_s  = ~vsync_in & s_vsync_r;
    // A wrap that coincides with an hfall is replaced by the reload, so it
    // does not advance the line count.
    assign h_wrap_s = (h_cnt_r == H_LAST_C) & ~hfall_s;

    // Horizontal position: reload on hfall, otherwise free-run modulo H_TOTAL
    always_comb begin
        h_cnt_nx_s = h_cnt_r;
        if (hfall_s) begin
            h_cnt_nx_s = H_SYNC_START_C;
        end else if (h_cnt_r == H_LAST_C) begin
            h_cnt_nx_s = 10'd0;
        end else begin
            h_cnt_nx_s = h_cnt_r + 10'd1;
        end
    end

    // Vertical position: vfall reload wins over the line increment
    always_comb begin
        v_cnt_nx_s = v_cnt_r;
        if (vfall_s) begin
            v_cnt_nx_s = V_SYNC_START_C;
        end else if (h_wrap_s) begin
            if (v_cnt_r == V_LAST_C) begin
                v_cnt_nx_s = 10'd0;
            end else begin
                v_cnt_nx_s = v_cnt_r + 10'd1;
            end
        end else begin
            v_cnt_nx_s = v_cnt_r;
        end
    end

    // Measurement counters; both saturate so a dead input cannot alias a good length
    always_comb begin
        h_len_nx_s = h_len_r;
        v_lines_s  = v_len_r;
        v_len_nx_s = v_len_r;
        lock_inc_s = lock_cnt_r;
        if (hfall_s) begin
            h_len_nx_s = 11'd1;
        end else if (h_len_r != MEAS_MAX_C) begin
            h_len_nx_s = h_len_r + 11'd1;
        end else begin
            h_len_nx_s = h_len_r;
        end
        // The wrap arriving with a vfall closes the frame being measured.
        if (h_wrap_s && (v_len_r != MEAS_MAX_C)) begin
            v_lines_s = v_len_r + 11'd1;
        end else begin
            v_lines_s = v_len_r;
        end
        if (vfall_s) begin
            v_len_nx_s = 11'd0;
        end else begin
            v_len_nx_s = v_lines_s;
        end
        if (lock_cnt_r != LOCK_MAX_C) begin
            lock_inc_s = lock_cnt_r + 4'd1;
        end else begin
            lock_inc_s = lock_cnt_r;
        end
    end

    assign h_viol_s     = hfall_s & h_meas_valid_r & (h_len_r != H_TOTAL_C);
    assign w_viol_s     = hrise_s & h_meas_valid_r & (h_len_r != H_WIDTH_C);
    assign v_viol_s     = vfall_s & v_meas_valid_r & (v_lines_s != V_TOTAL_C);
    assign any_viol_s   = h_viol_s | w_viol_s | v_viol_s;
    assign frame_good_s = vfall_s & v_meas_valid_r & ~v_viol_s & ~frame_bad_r;

    assign pix_valid_nx_s = locked & (h_cnt_r < H_ACTIVE_C) & (v_cnt_r < V_ACTIVE_C);

    // Stage 1: input sample, position and measurement counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_hsync_r      <= 1'b0;
            s_vsync_r      <= 1'b0;
            s_rgb_r        <= 3'd0;
            h_cnt_r        <= 10'd0;
            v_cnt_r        <= 10'd0;
            h_len_r        <= 11'd0;
            v_len_r        <= 11'd0;
            h_meas_valid_r <= 1'b0;
            v_meas_valid_r <= 1'b0;
        end else begin
            s_hsync_r <= hsync_in;
            s_vsync_r <= vsync_in;
            s_rgb_r   <= rgb_in;
            h_cnt_r   <= h_cnt_nx_s;
            v_cnt_r   <= v_cnt_nx_s;
            h_len_r   <= h_len_nx_s;
            v_len_r   <= v_len_nx_s;
            if (hfall_s) begin
                h_meas_valid_r <= 1'b1;
            end
            if (vfall_s) begin
                v_meas_valid_r <= 1'b1;
            end
        end
    end

    // Violation pulse, frame quality and lock tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_err    <= 1'b0;
            locked      <= 1'b0;
            lock_cnt_r  <= 4'd0;
            frame_bad_r <= 1'b0;
        end else begin
            sync_err <= any_viol_s;
            if (any_viol_s) begin
                locked     <= 1'b0;
                lock_cnt_r <= 4'd0;
            end else if (frame_good_s) begin
                lock_cnt_r <= lock_inc_s;
                if (lock_inc_s >= LOCK_FRAMES_C) begin
                    locked <= 1'b1;
                end
            end else begin
                lock_cnt_r <= lock_cnt_r;
            end
            // A frame-length error at a vfall describes the frame that just
            // ended, so only h/width errors in that cycle taint the new frame.
            if (vfall_s) begin
                frame_bad_r <= h_viol_s | w_viol_s;
            end else if (any_viol_s) begin
                frame_bad_r <= 1'b1;
            end else begin
                frame_bad_r <= frame_bad_r;
            end
        end
    end

    // Stage 2: tagged output pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_valid   <= 1'b0;
            red_out     <= 1'b0;
            green_out   <= 1'b0;
            blue_out    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_x       <= h_cnt_r;
            pix_y       <= v_cnt_r;
            pix_valid   <= pix_valid_nx_s;
            red_out     <= pix_valid_nx_s & s_rgb_r[0];
            green_out   <= pix_valid_nx_s & s_rgb_r[1];
            blue_out    <= pix_valid_nx_s & s_rgb_r[2];
            frame_start <= pix_valid_nx_s & (h_cnt_r == 10'd0) & (v_cnt_r == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ----------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Drives a reduced-geometry VGA stream (28x13, so frames are short) into the
// decoder, with random colours and one timing fault per perturbed frame: an
// extra clock on a line, a short hsync pulse, a missing line, or a 3-clock
// reset inside an hsync pulse. An event/timestamp reference model predicts
// every output each clock; frame-level counts check lock timing, pixel and
// frame_start counts, error pulses and re-lock.
// ----------------------------------------------------------------------------
module tb_vga_sync_decoder;

    localparam int HA  = 16;
    localparam int HSS = 20;
    localparam int HSE = 24;
    localparam int HT  = 28;
    localparam int VA  = 8;
    localparam int VSS = 10;
    localparam int VT  = 13;
    localparam int LF  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       hsync_in;
    logic       vsync_in;
    logic [2:0] rgb_in;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       pix_valid;
    logic       red_out;
    logic       green_out;
    logic       blue_out;
    logic       frame_start;
    logic       locked;
    logic       sync_err;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .frame_start(frame_start), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Checks one observed value against the expected one
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (timestamps and modular positions) ----
    int   m_n, m_ax, m_an, m_thf, m_lines, m_cx, m_cy, m_lcnt;
    bit   m_hv, m_vv, m_fbad, m_lk, m_psh, m_psv;
    logic [2:0] m_prgb;
    int   e_px, e_py;
    bit   e_valid, e_fs, e_lock, e_err;
    logic [2:0] e_rgb;

    task automatic model_step();
        bit hf, hr, vf, wr, herr, werr, verr, viol, good;
        int nx;
        if (reset) begin
            m_n = 0; m_ax = 0; m_an = 0; m_thf = 0; m_lines = 0;
            m_cx = 0; m_cy = 0; m_lcnt = 0;
            m_hv = 0; m_vv = 0; m_fbad = 0; m_lk = 0; m_psh = 0; m_psv = 0;
            m_prgb = 3'd0;
            e_px = 0; e_py = 0; e_valid = 0; e_fs = 0; e_lock = 0; e_err = 0;
            e_rgb = 3'd0;
            return;
        end
        m_n++;
        hf = !hsync_in && m_psh;
        hr = hsync_in && !m_psh;
        vf = !vsync_in && m_psv;
        // output stage sees the previous sample
        e_px    = m_cx;
        e_py    = m_cy;
        e_valid = m_lk && (m_cx < HA) && (m_cy < VA);
        e_rgb   = e_valid ? m_prgb : 3'd0;
        e_fs    = e_valid && (m_cx == 0) && (m_cy == 0);
        herr = hf && m_hv && ((m_n - m_thf) != HT);
        werr = hr && m_hv && ((m_n - m_thf) != (HSE - HSS));
        if (hf) begin
            m_ax = HSS; m_an = m_n; m_thf = m_n; m_hv = 1;
        end
        nx = (m_ax + m_n - m_an) % HT;
        wr = !hf && (nx == 0);
        if (wr) m_lines++;
        verr = vf && m_vv && (m_lines != VT);
        good = vf && m_vv && !verr && !m_fbad;
        if (vf) begin
            m_lines = 0; m_cy = VSS;
        end else if (wr) begin
            m_cy = (m_cy + 1) % VT;
        end
        m_cx = nx;
        viol = herr || werr || verr;
        if (viol) begin
            m_lcnt = 0; m_lk = 0;
        end else if (good) begin
            if (m_lcnt < 15) m_lcnt++;
            if (m_lcnt >= LF) m_lk = 1;
        end
        if (vf) m_fbad = herr || werr;
        else if (viol) m_fbad = 1;
        if (vf) m_vv = 1;
        e_err  = viol;
        e_lock = m_lk;
        m_psh  = hsync_in;
        m_psv  = vsync_in;
        m_prgb = rgb_in;
    endtask

    // ---------------- stimulus and per-cycle comparison ---------------------
    int cnt_err, cnt_valid, cnt_fs, vf_cnt;
    bit vs_prev, track_lock, prev_locked;

    task automatic tick(input logic hs, input logic vs, input logic [2:0] rgb, input logic rst_v);
        if (rst_v) begin
            vf_cnt = 0; track_lock = 1; vs_prev = 0;
        end else begin
            if (!vs && vs_prev) vf_cnt++;
            vs_prev = vs;
        end
        hsync_in = hs;
        vsync_in = vs;
        rgb_in   = rgb;
        reset    = rst_v;
        @(posedge clk);
        model_step();
        #1;
        check_val("pos", {12'd0, pix_x, pix_y}, {12'd0, 10'(e_px), 10'(e_py)});
        check_val("ctl", {25'd0, pix_valid, blue_out, green_out, red_out, frame_start, locked, sync_err},
                         {25'd0, e_valid, e_rgb[2], e_rgb[1], e_rgb[0], e_fs, e_lock, e_err});
        if (rst_v) begin
            check_val("rst_out", {pix_x, pix_y, pix_valid, red_out, green_out, blue_out,
                                  frame_start, locked, sync_err}, 32'd0);
        end
        if (sync_err) begin
            cnt_err++;
            check_val("lock_drop", {31'd0, locked}, 32'd0);
        end
        if (pix_valid) cnt_valid++;
        if (frame_start) cnt_fs++;
        if (locked && !prev_locked && track_lock) begin
            check_val("lock_vf", vf_cnt, LF + 1);
            track_lock = 0;
        end
        prev_locked = locked;
    endtask

    // mode: 0 clean, 1 extra clock on line bad, 2 short hsync on line bad,
    //       3 line bad missing, 4 reset for 3 clocks at x=rpos of line bad
    task automatic send_frame(input int mode, input int bad, input int rpos,
                              input int exp_err, input bit chk_pix, input bit rnd_rgb);
        int xlen;
        int hse_eff;
        logic hs, vs, rs;
        logic [2:0] col;
        cnt_err = 0; cnt_valid = 0; cnt_fs = 0;
        for (int y = 0; y < VT; y++) begin
            if (mode == 3 && y == bad) continue;
            xlen    = (mode == 1 && y == bad) ? HT + 1 : HT;
            hse_eff = (mode == 2 && y == bad) ? HSE - 1 : HSE;
            for (int x = 0; x < xlen; x++) begin
                hs  = !(x >= HSS && x < hse_eff);
                vs  = !(y >= VSS && y < VSS + 2);
                rs  = (mode == 4 && y == bad && x >= rpos && x < rpos + 3);
                col = rnd_rgb ? 3'($urandom) : 3'b101;
                tick(hs, vs, col, rs);
            end
        end
        check_val("err_cnt", cnt_err, exp_err);
        if (chk_pix) begin
            check_val("valid_cnt", cnt_valid, HA * VA);
            check_val("fs_cnt", cnt_fs, 1);
        end
    endtask

    initial begin
        int mode, bad, rpos;
        hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 3'd0; reset = 1'b1;
        vf_cnt = 0; vs_prev = 0; track_lock = 1; prev_locked = 0;
        repeat (4) tick(1'b1, 1'b1, 3'd0, 1'b1);

        // Ideal stream with constant colour: lock at the 3rd vfall, then full frames
        for (int f = 0; f < 5; f++) begin
            send_frame(0, 0, 0, 0, (f >= 3), 1'b0);
        end
        check_val("locked_ideal", {31'd0, locked}, 32'd1);

        // One fault per frame, each followed by clean frames that must re-lock
        for (int i = 0; i < 12; i++) begin
            mode = 1 + (i % 4);
            rpos = HSS + $urandom_range(0, HSE - HSS - 3);
            case (mode)
                1:       bad = $urandom_range(0, VT - 2);
                2:       bad = $urandom_range(0, VT - 1);
                3:       bad = $urandom_range(0, VSS - 1);
                default: bad = $urandom_range(0, VA - 1);
            endcase
            send_frame(mode, bad, rpos, (mode == 4) ? 0 : 1, 1'b0, 1'b1);
            repeat (3) send_frame(0, 0, 0, 0, 1'b0, 1'b1);
            check_val("relock", {31'd0, locked}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
